// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: occupancy states, command encoding and strobe decode for the operand stack.
package operand_stack_pkg;
    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} occ_t;
    typedef enum logic [2:0] {C_NONE, C_PUSH, C_POP, C_TOS, C_ILLEGAL} cmd_t;
    function automatic cmd_t decode_cmd(input logic push, input logic pop, input logic tos);
        return ({push, pop, tos} == 3'b000) ? C_NONE :
               ({push, pop, tos} == 3'b100) ? C_PUSH :
               ({push, pop, tos} == 3'b010) ? C_POP  :
               ({push, pop, tos} == 3'b001) ? C_TOS  : C_ILLEGAL;
    endfunction
endpackage

// File: rtl/operand_stack_if.sv
// operand_stack_if: controller-facing strobes, data and status of the operand stack.
interface operand_stack_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
    localparam int PW = $clog2(DEPTH + 1);
    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clear;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] stack_out;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err_overflow;
    logic             err_underflow;
    logic             err_conflict;
    modport master (
        output push, pop, tos, err_clear, push_data,
        input  stack_out, count, empty, full, err_overflow, err_underflow, err_conflict
    );
    modport slave (
        input  push, pop, tos, err_clear, push_data,
        output stack_out, count, empty, full, err_overflow, err_underflow, err_conflict
    );
endinterface

// File: rtl/operand_stack_ram.sv
// operand_stack_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset.
module operand_stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stack.sv
// operand_stack: bounded LIFO with registered read port and sticky misuse flags.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    operand_stack_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    logic [PW-1:0]    count_q, count_d, top_idx;
    logic [WIDTH-1:0] out_q, out_d, rdata;
    logic             ovf_q, ovf_d, und_q, und_d, conf_q, conf_d, we;
    occ_t             occ_q, occ_d;
    cmd_t             cmd;
    assign cmd     = decode_cmd(bus.push, bus.pop, bus.tos);
    // never form an index from count-1 while the stack is empty
    assign top_idx = (count_q != '0) ? count_q - PW'(1) : '0;
    operand_stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[AW-1:0]),
        .wdata (bus.push_data),
        .raddr (top_idx[AW-1:0]),
        .rdata (rdata)
    );
    always_comb begin
        count_d = count_q;
        out_d   = out_q;
        we      = 1'b0;
        ovf_d   = ovf_q & ~bus.err_clear;
        und_d   = und_q & ~bus.err_clear;
        conf_d  = conf_q & ~bus.err_clear;
        case (cmd)
            C_PUSH: if (occ_q == S_FULL) ovf_d = 1'b1;
                    else begin
                        we      = 1'b1;
                        count_d = count_q + PW'(1);
                    end
            C_POP: if (occ_q == S_EMPTY) und_d = 1'b1;
                   else begin
                       out_d   = rdata;
                       count_d = count_q - PW'(1);
                   end
            C_TOS: begin
                out_d = (occ_q == S_EMPTY) ? '0 : rdata;
                und_d = und_d | (occ_q == S_EMPTY);
            end
            C_ILLEGAL: conf_d = 1'b1;
            default: ;
        endcase
        occ_d = (count_d == '0) ? S_EMPTY : (count_d == DEPTH_C) ? S_FULL : S_PART;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
            conf_q  <= 1'b0;
            occ_q   <= S_EMPTY;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            und_q   <= und_d;
            conf_q  <= conf_d;
            occ_q   <= occ_d;
        end
    end
    assign bus.stack_out     = out_q;
    assign bus.count         = count_q;
    assign bus.empty         = (count_q == '0);
    assign bus.full          = (count_q == DEPTH_C);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = und_q;
    assign bus.err_conflict  = conf_q;
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed vector table plus a randomized run against a queue-based stack model.
module tb_operand_stack;
    localparam int W = 8;
    localparam int D = 8;
    typedef struct {
        logic         rst, push, pop, tos;
        logic [W-1:0] d;
        logic         clr;
        logic [W-1:0] e_out;
        int           e_cnt;
        logic         e_ovf, e_und, e_conf;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int step = 0;
    vec_t tbl[$];
    vec_t expq[$];
    logic [W-1:0] m_stk[$];
    logic [W-1:0] m_out;
    logic m_ovf, m_und, m_conf;
    operand_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();
    operand_stack #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic vec_t mk(logic r, logic pu, logic po, logic t, logic [W-1:0] d, logic c,
                                logic [W-1:0] eo, int ec, logic eov, logic eun, logic eco);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.tos = t; v.d = d; v.clr = c;
        v.e_out = eo; v.e_cnt = ec; v.e_ovf = eov; v.e_und = eun; v.e_conf = eco;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
        end
    endtask
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst;
        bus.push = v.push; bus.pop = v.pop; bus.tos = v.tos;
        bus.push_data = v.d; bus.err_clear = v.clr;
        expq.push_back(v);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        chk("stack_out", 32'(bus.stack_out), 32'(e.e_out));
        chk("count", 32'(bus.count), 32'(e.e_cnt));
        chk("empty", 32'(bus.empty), 32'(e.e_cnt == 0));
        chk("full", 32'(bus.full), 32'(e.e_cnt == D));
        chk("err_overflow", 32'(bus.err_overflow), 32'(e.e_ovf));
        chk("err_underflow", 32'(bus.err_underflow), 32'(e.e_und));
        chk("err_conflict", 32'(bus.err_conflict), 32'(e.e_conf));
        step++;
    endtask
    task automatic model_step(inout vec_t v);
        int n;
        n = int'(v.push) + int'(v.pop) + int'(v.tos);
        if (v.rst) begin
            m_stk.delete();
            m_out = '0; m_ovf = 1'b0; m_und = 1'b0; m_conf = 1'b0;
        end else begin
            if (v.clr) begin
                m_ovf = 1'b0; m_und = 1'b0; m_conf = 1'b0;
            end
            if (n > 1) m_conf = 1'b1;
            else if (v.push) begin
                if (m_stk.size() == D) m_ovf = 1'b1;
                else m_stk.push_back(v.d);
            end else if (v.pop) begin
                if (m_stk.size() == 0) m_und = 1'b1;
                else m_out = m_stk.pop_back();
            end else if (v.tos) begin
                if (m_stk.size() == 0) begin
                    m_out = '0; m_und = 1'b1;
                end else m_out = m_stk[$];
            end
        end
        v.e_out = m_out; v.e_cnt = m_stk.size();
        v.e_ovf = m_ovf; v.e_und = m_und; v.e_conf = m_conf;
    endtask
    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
        bus.push_data = '0; bus.err_clear = 1'b0;
        tbl.push_back(mk(1,0,0,0,8'h00,0, 8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h00,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00,1, 8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h11,0, 8'h00,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h22,0, 8'h00,2,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h33,0, 8'h00,3,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h33,3,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h33,2,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h22,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h11,0,0,0,0));
        for (int k = 1; k <= D; k++) tbl.push_back(mk(0,1,0,0,8'(8'h80 + k),0, 8'h11,k,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'hAA,0, 8'h11,8,1,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h88,7,1,0,0));
        tbl.push_back(mk(0,0,0,0,8'h00,1, 8'h88,7,0,0,0));
        for (int k = 7; k >= 1; k--) tbl.push_back(mk(0,0,1,0,8'h00,0, 8'(8'h80 + k),k-1,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h11,0, 8'h81,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h22,0, 8'h81,2,0,0,0));
        tbl.push_back(mk(0,1,1,0,8'h99,0, 8'h81,2,0,0,1));
        tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h22,2,0,0,1));
        tbl.push_back(mk(0,0,0,0,8'h00,1, 8'h22,2,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h22,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,0, 8'h11,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00,1, 8'h11,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00,1, 8'h11,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h00,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,8'h77,1, 8'h00,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,8'h00,1, 8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,8'h5A,0, 8'h00,1,0,0,0));
        tbl.push_back(mk(1,0,1,0,8'h00,0, 8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,8'h00,0, 8'h00,0,0,1,0));
        foreach (tbl[i]) apply(tbl[i]);
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            logic [2:0] b;
            int sel;
            sel = int'($urandom_range(0, 9));
            b = (sel < 4) ? 3'b100 : (sel < 6) ? 3'b010 : (sel < 8) ? 3'b001 : 3'($urandom_range(0, 7));
            v = mk((i == 0) || ($urandom_range(0, 79) == 0), b[2], b[1], b[0],
                   8'($urandom), $urandom_range(0, 9) == 0, '0, 0, 0, 0, 0);
            model_step(v);
            apply(v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
